ssd1309_rx: RTL and testbench

- Panel-side receiver for the SSD1309 4-wire SPI link that the OLED driver produces; a behavioural-grade synthesizable model of the display controller front end.
- Oversamples cs/dc/sclk/mosi on the system clock, assembles bytes MSB-first and decodes the command subset the driver issues.
- Routes data bytes to a page/column framebuffer write port with SSD1309 auto-increment addressing.
- Used for on-chip loopback verification and as the capture front end for a mirrored/emulated display.

---
 rtl/ssd1309_pkg.sv | 44 ++++
 rtl/ssd1309_rx_spi_byte_rx.sv | 128 ++++++++++++
 rtl/ssd1309_rx.sv | 210 +++++++++++++++++++++
 tb/tb_ssd1309_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd1309_pkg.sv
// -----------------------------------------------------------------------------
// ssd1309_pkg
// Shared definitions for the SSD1309 4-wire SPI link: command opcodes issued
// by the OLED driver, addressing-mode encoding, receiver decoder states and
// framebuffer address field widths.
// -----------------------------------------------------------------------------
package ssd1309_pkg;

  // Command opcodes (driver and receiver agree on these)
  localparam logic [7:0] OP_DISP_OFF = 8'hAE;
  localparam logic [7:0] OP_DISP_ON  = 8'hAF;
  localparam logic [7:0] OP_CLKDIV   = 8'hD5;
  localparam logic [7:0] OP_CONTRAST = 8'h81;
  localparam logic [7:0] OP_MODE     = 8'h20;
  localparam logic [7:0] OP_COLADDR  = 8'h21;
  localparam logic [7:0] OP_PAGEADDR = 8'h22;

  // Framebuffer address fields: {page, col}
  localparam int COL_W  = 7;
  localparam int PAGE_W = 3;

  // Last bit index of a serial byte
  localparam logic [2:0] LAST_BIT = 3'd7;

  // Memory addressing modes; the reserved code behaves like page mode
  typedef enum logic [1:0] {
    AM_HORIZ = 2'd0,
    AM_VERT  = 2'd1,
    AM_PAGE  = 2'd2,
    AM_RSVD  = 2'd3
  } addr_mode_e;

  // Command decoder states; argument states wait for the next command byte
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARG_MODE  = 3'd1,
    ST_ARG1_SKIP = 3'd2,
    ST_COL_S     = 3'd3,
    ST_COL_E     = 3'd4,
    ST_PAGE_S    = 3'd5,
    ST_PAGE_E    = 3'd6
  } dec_state_e;

endpackage

// File: rtl/ssd1309_rx_spi_byte_rx.sv
// -----------------------------------------------------------------------------
// spi_byte_rx
// Oversampling SPI byte receiver. Synchronises cs/dc/sclk/mosi/oled_rst,
// detects sclk rising edges while cs is low, shifts bits MSB-first and
// captures dc on the 8th edge.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   oled_rst     panel reset pin (active-low, asynchronous to clk)
//   cs,dc,sclk,mosi  raw SPI pins
//   panel_rst    combined reset (rst or synchronised oled_rst low)
//   byte_o       last completed byte
//   is_data      dc level captured with byte_o
//   valid        one-cycle pulse per completed byte
// -----------------------------------------------------------------------------
module spi_byte_rx
  import ssd1309_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oled_rst,
  input  logic       cs,
  input  logic       dc,
  input  logic       sclk,
  input  logic       mosi,
  output logic       panel_rst,
  output logic [7:0] byte_o,
  output logic       is_data,
  output logic       valid
);

  logic [SYNC_STAGES-1:0] orst_sync_q, orst_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] dc_sync_q, dc_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             shift_q, shift_d;
  logic [7:0]             byte_q, byte_d;
  logic                   is_data_q, is_data_d;
  logic                   valid_q, valid_d;

  logic cs_s, dc_s, sclk_s, mosi_s, sclk_rise, soft_rst;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  // The panel reset pin acts exactly like rst once synchronised
  assign soft_rst  = rst | ~orst_sync_q[SYNC_STAGES-1];

  assign panel_rst = soft_rst;
  assign byte_o    = byte_q;
  assign is_data   = is_data_q;
  assign valid     = valid_q;

  // Next-state for synchronisers, edge detector and shift register
  always_comb begin
    orst_sync_d = {orst_sync_q[SYNC_STAGES-2:0], oled_rst};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    dc_sync_d   = {dc_sync_q[SYNC_STAGES-2:0], dc};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    is_data_d   = is_data_q;
    valid_d     = 1'b0;
    if (cs_s) begin
      // Deselect drops any partial byte
      bit_cnt_d = 3'd0;
    end else if (sclk_rise) begin
      if (bit_cnt_q == LAST_BIT) begin
        // Seven earlier bits sit in shift_q; the eighth comes straight from mosi
        byte_d    = {shift_q, mosi_s};
        is_data_d = dc_s;
        valid_d   = 1'b1;
        bit_cnt_d = 3'd0;
      end else begin
        shift_d   = {shift_q[5:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // oled_rst synchroniser, cleared only by the system reset
  always_ff @(posedge clk) begin
    if (rst) begin
      orst_sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      orst_sync_q <= orst_sync_d;
    end
  end

  // Pin synchronisers and byte assembly state
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      dc_sync_q   <= {SYNC_STAGES{1'b0}};
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      byte_q      <= 8'd0;
      is_data_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      dc_sync_q   <= dc_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      is_data_q   <= is_data_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: rtl/ssd1309_rx.sv
// -----------------------------------------------------------------------------
// ssd1309_rx
// Panel-side SSD1309 4-wire SPI receiver: decodes the driver's command subset
// and turns data bytes into framebuffer writes with auto-increment addressing.
// Ports:
//   clk, rst      system clock (>= 4x sclk), synchronous active-high reset
//   oled_rst      panel reset pin, active-low
//   cs,dc,sclk,mosi  SPI link from the driver
//   fb_we/fb_addr/fb_data  framebuffer write port, addr = {page, col}
//   display_on    display enable from 0xAF/0xAE
//   addr_mode     0 horizontal, 1 vertical, 2/3 page
//   frame_done    pulse with the write that wraps the whole window
//   byte_valid/byte_out  debug view of every received byte
// -----------------------------------------------------------------------------
module ssd1309_rx
  import ssd1309_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oled_rst,
  input  logic       cs,
  input  logic       dc,
  input  logic       sclk,
  input  logic       mosi,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_data,
  output logic       display_on,
  output logic [1:0] addr_mode,
  output logic       frame_done,
  output logic       byte_valid,
  output logic [7:0] byte_out
);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

  logic       panel_rst, rx_is_data, rx_valid;
  logic [7:0] rx_byte;

  dec_state_e        state_q, state_d;
  addr_mode_e        addr_mode_q, addr_mode_d;
  logic              display_on_q, display_on_d;
  logic [COL_W-1:0]  col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
  logic [PAGE_W-1:0] page_start_q, page_start_d, page_end_q, page_end_d, page_q, page_d;
  logic              fb_we_q, fb_we_d, frame_done_q, frame_done_d;
  logic [9:0]        fb_addr_q, fb_addr_d;
  logic [7:0]        fb_data_q, fb_data_d;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .oled_rst  (oled_rst),
    .cs        (cs),
    .dc        (dc),
    .sclk      (sclk),
    .mosi      (mosi),
    .panel_rst (panel_rst),
    .byte_o    (rx_byte),
    .is_data   (rx_is_data),
    .valid     (rx_valid)
  );

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign display_on = display_on_q;
  assign addr_mode  = addr_mode_q;
  assign frame_done = frame_done_q;
  assign byte_valid = rx_valid;
  assign byte_out   = rx_byte;

  // Command decoder, write strobe and write-pointer advance
  always_comb begin
    state_d      = state_q;
    addr_mode_d  = addr_mode_q;
    display_on_d = display_on_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    col_d        = col_q;
    page_d       = page_q;
    fb_we_d      = 1'b0;
    frame_done_d = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    if (rx_valid && rx_is_data) begin
      // Data never disturbs a pending command argument
      fb_we_d   = 1'b1;
      fb_addr_d = {page_q, col_q};
      fb_data_d = rx_byte;
      case (addr_mode_q)
        AM_HORIZ: begin
          if (col_q == col_end_q) begin
            col_d = col_start_q;
            if (page_q == page_end_q) begin
              page_d       = page_start_q;
              frame_done_d = 1'b1;
            end else begin
              page_d = page_q + 3'd1;
            end
          end else begin
            col_d = col_q + 7'd1;
          end
        end
        AM_VERT: begin
          if (page_q == page_end_q) begin
            page_d = page_start_q;
            if (col_q == col_end_q) begin
              col_d        = col_start_q;
              frame_done_d = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            page_d = page_q + 3'd1;
          end
        end
        default: begin
          // Page mode (and reserved code): column wraps within the page
          if (col_q == col_end_q) begin
            col_d = col_start_q;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      endcase
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          case (rx_byte)
            OP_DISP_OFF: display_on_d = 1'b0;
            OP_DISP_ON:  display_on_d = 1'b1;
            OP_CLKDIV:   state_d = ST_ARG1_SKIP;
            OP_CONTRAST: state_d = ST_ARG1_SKIP;
            OP_MODE:     state_d = ST_ARG_MODE;
            OP_COLADDR:  state_d = ST_COL_S;
            OP_PAGEADDR: state_d = ST_PAGE_S;
            default:     state_d = ST_IDLE;
          endcase
        end
        ST_ARG_MODE: begin
          addr_mode_d = addr_mode_e'(rx_byte[1:0]);
          state_d     = ST_IDLE;
        end
        ST_ARG1_SKIP: state_d = ST_IDLE;
        ST_COL_S: begin
          col_start_d = rx_byte[6:0];
          state_d     = ST_COL_E;
        end
        ST_COL_E: begin
          col_end_d = rx_byte[6:0];
          col_d     = col_start_q;
          state_d   = ST_IDLE;
        end
        ST_PAGE_S: begin
          page_start_d = rx_byte[2:0];
          state_d      = ST_PAGE_E;
        end
        ST_PAGE_E: begin
          page_end_d = rx_byte[2:0];
          page_d     = page_start_q;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Decoder/pointer registers and registered framebuffer outputs
  always_ff @(posedge clk) begin
    if (panel_rst) begin
      state_q      <= ST_IDLE;
      addr_mode_q  <= AM_PAGE;
      display_on_q <= 1'b0;
      col_start_q  <= 7'd0;
      col_end_q    <= COL_LAST;
      page_start_q <= 3'd0;
      page_end_q   <= PAGE_LAST;
      col_q        <= 7'd0;
      page_q       <= 3'd0;
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      fb_addr_q    <= 10'd0;
      fb_data_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      addr_mode_q  <= addr_mode_d;
      display_on_q <= display_on_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      col_q        <= col_d;
      page_q       <= page_d;
      fb_we_q      <= fb_we_d;
      frame_done_q <= frame_done_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
    end
  end

endmodule

// File: tb/tb_ssd1309_rx.sv
// -----------------------------------------------------------------------------
// tb_ssd1309_rx
// Directed bench for ssd1309_rx. Bytes are driven over the SPI pins; each
// expected framebuffer write is queued before its byte is sent and checked
// when the DUT raises fb_we.
// -----------------------------------------------------------------------------
module tb_ssd1309_rx;

  logic       clk = 1'b0;
  logic       rst, oled_rst, cs, dc, sclk, mosi;
  logic       fb_we, display_on, frame_done, byte_valid;
  logic [9:0] fb_addr;
  logic [7:0] fb_data, byte_out;
  logic [1:0] addr_mode;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
    logic       fd;
  } wr_t;

  wr_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  bv_cnt = 0;

  ssd1309_rx dut (
    .clk        (clk),
    .rst        (rst),
    .oled_rst   (oled_rst),
    .cs         (cs),
    .dc         (dc),
    .sclk       (sclk),
    .mosi       (mosi),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .display_on (display_on),
    .addr_mode  (addr_mode),
    .frame_done (frame_done),
    .byte_valid (byte_valid),
    .byte_out   (byte_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input int page, input int col, input int data, input bit fd);
    wr_t e;
    e.addr = 10'((page << 7) | col);
    e.data = 8'(data);
    e.fd   = fd;
    sb.push_back(e);
  endtask

  // Full byte: 8 sclk periods of 4 clk each, then deselect
  task automatic send_byte(input logic [7:0] b, input logic d);
    @(negedge clk);
    cs = 1'b0;
    dc = d;
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      sclk = 1'b0;
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask

  // Write-port monitor: pops the scoreboard on every strobe
  always @(negedge clk) begin
    wr_t e;
    if (byte_valid) bv_cnt <= bv_cnt + 1;
    if (fb_we) begin
      if (sb.size() == 0) begin
        chk("spurious_fb_we", 32'(fb_we), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("fb_addr", 32'(fb_addr), 32'(e.addr));
        chk("fb_data", 32'(fb_data), 32'(e.data));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
      end
    end else if (frame_done) begin
      chk("frame_done_without_we", 32'(frame_done), 32'd0);
    end
  end

  initial begin
    int   bv_base;
    int   pg3[7];
    int   cl3[7];
    rst = 1'b1; oled_rst = 1'b1; cs = 1'b1; dc = 1'b0; sclk = 1'b0; mosi = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_data", 32'(fb_data), 32'd0);
    chk("rst_display_on", 32'(display_on), 32'd0);
    chk("rst_addr_mode", 32'(addr_mode), 32'd2);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_out", 32'(byte_out), 32'd0);

    // Display on/off, no framebuffer activity expected
    send_cmd(8'hAF);
    chk("disp_on", 32'(display_on), 32'd1);
    chk("byte_out_af", 32'(byte_out), 32'hAF);
    send_cmd(8'hAE);
    chk("disp_off", 32'(display_on), 32'd0);

    // Full-screen horizontal fill plus one wrap byte
    send_cmd(8'h20); send_cmd(8'h00);
    send_cmd(8'h21); send_cmd(8'h00); send_cmd(8'h7F);
    send_cmd(8'h22); send_cmd(8'h00); send_cmd(8'h3F);
    chk("mode_horiz", 32'(addr_mode), 32'd0);
    for (int n = 0; n < 1025; n++) begin
      exp_wr((n % 1024) / 128, n % 128, n % 256, (n == 1023));
      send_byte(n[7:0], 1'b1);
    end
    drain("drain_full_frame");

    // Small window 16..18 x 3..4 in horizontal mode
    send_cmd(8'h21); send_cmd(8'h10); send_cmd(8'h12);
    send_cmd(8'h22); send_cmd(8'h03); send_cmd(8'h04);
    pg3 = '{3, 3, 3, 4, 4, 4, 3};
    cl3 = '{16, 17, 18, 16, 17, 18, 16};
    for (int k = 0; k < 7; k++) begin
      exp_wr(pg3[k], cl3[k], 8'hA0 + k, (k == 5));
      send_byte(8'(8'hA0 + k), 1'b1);
    end
    drain("drain_window");

    // Page mode: column wraps 126,127,126 on page 3, never frame_done
    send_cmd(8'h20); send_cmd(8'h02);
    send_cmd(8'h21); send_cmd(8'h7E); send_cmd(8'h7F);
    chk("mode_page", 32'(addr_mode), 32'd2);
    exp_wr(3, 126, 8'h11, 1'b0);
    send_byte(8'h11, 1'b1);
    exp_wr(3, 127, 8'h22, 1'b0);
    send_byte(8'h22, 1'b1);
    exp_wr(3, 126, 8'h33, 1'b0);
    send_byte(8'h33, 1'b1);
    drain("drain_page_mode");

    // Partial byte dropped by cs rising, then a clean 0xAF
    bv_base = bv_cnt;
    @(negedge clk);
    cs = 1'b0; dc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1; sclk = 1'b0;
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    send_cmd(8'hAF);
    chk("partial_disp_on", 32'(display_on), 32'd1);
    chk("partial_byte_out", 32'(byte_out), 32'hAF);
    chk("partial_bv_count", 32'(bv_cnt - bv_base), 32'd1);

    // Panel reset mid-command, horizontal mode selected beforehand
    send_cmd(8'h20); send_cmd(8'h00);
    chk("mode_horiz2", 32'(addr_mode), 32'd0);
    send_cmd(8'h21);
    oled_rst = 1'b0;
    repeat (5) @(negedge clk);
    oled_rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("orst_addr_mode", 32'(addr_mode), 32'd2);
    chk("orst_display_on", 32'(display_on), 32'd0);
    chk("orst_byte_out", 32'(byte_out), 32'd0);
    exp_wr(0, 0, 8'h55, 1'b0);
    send_byte(8'h55, 1'b1);
    drain("drain_after_orst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
